// File: rtl/mcdt_fmt_pkg.sv
// Shared types, header field positions and the packet-length decode for mcdt_formatter.
// The TRL state exists only when MCDT_FMT_PARITY_EN is defined.
package mcdt_fmt_pkg;

`ifdef MCDT_FMT_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_HDR, ST_PAY, ST_TRL} fmt_state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_HDR, ST_PAY} fmt_state_e;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } fifo_entry_t;

    localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;
    localparam int HDR_TAG_LSB = 24;
    localparam int HDR_ID_LSB  = 16;
    localparam int HDR_SEQ_LSB = 0;

    // 00->4, 01->8, 10->16, 11->32 payload words
    function automatic logic [5:0] pkt_len_decode(input logic [1:0] code);
        return 6'd4 << code;
    endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Synchronous show-ahead FIFO of {id,data} entries with occupancy count.
// Exposes the head entry and the id of the entry behind it for end-of-packet lookahead.
module mcdt_fmt_fifo
    import mcdt_fmt_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  fifo_entry_t   wdata_i,
    input  logic          pop_i,
    output fifo_entry_t   head_o,
    output logic [1:0]    head_next_id_o,
    output logic [CW-1:0] count_o,
    output logic          push_ok_o
);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o         = mem_q[rd_ptr_q];
    assign head_next_id_o = mem_q[rd_ptr_q + AW'(1)].id;
    assign count_o        = count_q;
    assign push_ok_o      = do_push;

endmodule

// File: rtl/mcdt_formatter.sv
// Packetises arbitrated mcdt channel words into header + payload bursts with a request/grant handshake.
// Optional XOR trailer word enabled by defining MCDT_FMT_PARITY_EN.
module mcdt_formatter
    import mcdt_fmt_pkg::*;
#(
    parameter int         FIFO_DEPTH = 32,
    parameter logic [7:0] HDR_TAG    = HDR_TAG_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] mcdt_data_i,
    input  logic        mcdt_val_i,
    input  logic [1:0]  mcdt_id_i,
    input  logic [1:0]  pkt_len_i,
    input  logic        fmt_grant_i,
    output logic        fmt_req_o,
    output logic        fmt_start_o,
    output logic [31:0] fmt_data_o,
    output logic [1:0]  fmt_id_o,
    output logic        fmt_end_o,
    output logic [6:0]  fmt_margin_o,
    output logic        fmt_ovf_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fmt_state_e    state_q, state_d;
    logic [15:0]   seq_q, seq_d;
    logic [1:0]    id_q, id_d;
    logic [5:0]    len_q, len_d;
    logic [5:0]    pay_cnt_q, pay_cnt_d;
    logic          ovf_q;
`ifdef MCDT_FMT_PARITY_EN
    logic [31:0]   par_q, par_d;
`endif

    fifo_entry_t   wr_entry;
    fifo_entry_t   head;
    logic [1:0]    head_next_id;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop;
    logic          is_last;
    logic [31:0]   hdr_word;

    assign wr_entry = {mcdt_id_i, mcdt_data_i};

    mcdt_fmt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .push_i         (mcdt_val_i),
        .wdata_i        (wr_entry),
        .pop_i          (pop),
        .head_o         (head),
        .head_next_id_o (head_next_id),
        .count_o        (count),
        .push_ok_o      (push_ok)
    );

    // Words arriving in the same cycle as the final pop never extend the packet
    assign is_last = (pay_cnt_q + 6'd1 == len_q) || (count == CW'(1)) || (head_next_id != id_q);

    always_comb begin
        hdr_word                       = '0;
        hdr_word[HDR_TAG_LSB +: 8]     = HDR_TAG;
        hdr_word[HDR_ID_LSB +: 2]      = id_q;
        hdr_word[HDR_SEQ_LSB +: 16]    = seq_q;
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        id_d        = id_q;
        len_d       = len_q;
        pay_cnt_d   = pay_cnt_q;
`ifdef MCDT_FMT_PARITY_EN
        par_d       = par_q;
`endif
        pop         = 1'b0;
        fmt_req_o   = 1'b0;
        fmt_start_o = 1'b0;
        fmt_end_o   = 1'b0;
        fmt_data_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) state_d = ST_REQ;
            end
            ST_REQ: begin
                fmt_req_o = 1'b1;
                if (fmt_grant_i) begin
                    state_d = ST_HDR;
                    id_d    = head.id;
                    len_d   = pkt_len_decode(pkt_len_i);
                end
            end
            ST_HDR: begin
                fmt_start_o = 1'b1;
                fmt_data_o  = hdr_word;
                pay_cnt_d   = '0;
`ifdef MCDT_FMT_PARITY_EN
                par_d       = '0;
`endif
                state_d     = ST_PAY;
            end
            ST_PAY: begin
                pop        = 1'b1;
                fmt_data_o = head.data;
                pay_cnt_d  = pay_cnt_q + 6'd1;
`ifdef MCDT_FMT_PARITY_EN
                par_d      = par_q ^ head.data;
                if (is_last) state_d = ST_TRL;
`else
                if (is_last) begin
                    fmt_end_o = 1'b1;
                    seq_d     = seq_q + 16'd1;
                    state_d   = ST_IDLE;
                end
`endif
            end
`ifdef MCDT_FMT_PARITY_EN
            ST_TRL: begin
                fmt_data_o = par_q;
                fmt_end_o  = 1'b1;
                seq_d      = seq_q + 16'd1;
                state_d    = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            seq_q     <= '0;
            id_q      <= '0;
            len_q     <= '0;
            pay_cnt_q <= '0;
            ovf_q     <= 1'b0;
`ifdef MCDT_FMT_PARITY_EN
            par_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            id_q      <= id_d;
            len_q     <= len_d;
            pay_cnt_q <= pay_cnt_d;
            ovf_q     <= mcdt_val_i && !push_ok;
`ifdef MCDT_FMT_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign fmt_id_o     = id_q;
    assign fmt_ovf_o    = ovf_q;
    assign fmt_margin_o = 7'(FIFO_DEPTH) - 7'(count);

endmodule

// File: tb/tb_mcdt_formatter.sv
// Self-checking bench for mcdt_formatter: random word streams checked against a packet-level model.
// Covers the MCDT_FMT_PARITY_EN trailer when the macro is defined for the build.
module tb_mcdt_formatter;

    localparam int DEPTH = 32;
`ifdef MCDT_FMT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {logic s; logic e; logic [1:0] id; logic [31:0] d;} ev_t;
    typedef struct packed {logic [1:0] id; logic [31:0] d;} wr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] mcdt_data = '0;
    logic        mcdt_val = 1'b0;
    logic [1:0]  mcdt_id = '0;
    logic [1:0]  pkt_len = '0;
    logic        grant = 1'b0;
    logic        fmt_req_o, fmt_start_o, fmt_end_o, fmt_ovf_o;
    logic [31:0] fmt_data_o;
    logic [1:0]  fmt_id_o;
    logic [6:0]  fmt_margin_o;

    always #5 clk = ~clk;

    mcdt_formatter #(.FIFO_DEPTH(DEPTH), .HDR_TAG(8'hA5)) dut (
        .clk_i(clk), .rstn_i(rstn), .mcdt_data_i(mcdt_data), .mcdt_val_i(mcdt_val),
        .mcdt_id_i(mcdt_id), .pkt_len_i(pkt_len), .fmt_grant_i(grant),
        .fmt_req_o(fmt_req_o), .fmt_start_o(fmt_start_o), .fmt_data_o(fmt_data_o),
        .fmt_id_o(fmt_id_o), .fmt_end_o(fmt_end_o), .fmt_margin_o(fmt_margin_o),
        .fmt_ovf_o(fmt_ovf_o)
    );

    int errors = 0;
    int checks = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    wr_t wq[$];
    logic [1:0] lens_q[$];
    int ovf_seen = 0, exp_ovf = 0, ends_seen = 0, cyc = 0, last_end_cyc = 0;
    bit in_pkt = 0, have_end = 0;
    logic [15:0] seq_model = '0;

    function automatic ev_t mk(input logic s, input logic e, input logic [1:0] id, input logic [31:0] d);
        ev_t r;
        r.s = s; r.e = e; r.id = id; r.d = d;
        return r;
    endfunction

    // One clock; outputs sampled on the falling edge and recorded as packet events
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (fmt_ovf_o) ovf_seen++;
        if (fmt_start_o) begin
            $display("pkt start id=%0d hdr=%h len_code=%0d", fmt_id_o, fmt_data_o, pkt_len);
            lens_q.push_back(pkt_len);
            checks++;
            if (have_end && (cyc - last_end_cyc) < 3) begin
                errors++;
                $display("FAIL gap: %0d cycles from end to start, required >= 3", cyc - last_end_cyc);
            end
        end
        if (fmt_start_o || in_pkt) begin
            obs_q.push_back(mk(fmt_start_o, fmt_end_o, fmt_id_o, fmt_data_o));
            in_pkt = !fmt_end_o;
        end
        if (fmt_end_o) begin
            last_end_cyc = cyc; have_end = 1; ends_seen++;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete(); lens_q.delete(); exp_q.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0; grant = 1'b0; mcdt_val = 1'b1; mcdt_data = $urandom; mcdt_id = 2'($urandom);
        tick(); tick();
        rstn = 1'b1; mcdt_val = 1'b0;
        clear_obs(); wq.delete();
        in_pkt = 0; have_end = 0; seq_model = '0; ovf_seen = 0; exp_ovf = 0;
    endtask

    task automatic write_word(input logic [1:0] id, input logic [31:0] d);
        wr_t w;
        mcdt_val = 1'b1; mcdt_id = id; mcdt_data = d;
        w.id = id; w.d = d;
        if (wq.size() < DEPTH) wq.push_back(w);
        else exp_ovf++;
        tick();
        mcdt_val = 1'b0;
    endtask

    task automatic drain(input bit rand_len, output bit done);
        grant = 1'b1; done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (rand_len && fmt_start_o) pkt_len = 2'($urandom_range(0, 3));
            if (!in_pkt && !fmt_req_o && !fmt_start_o && fmt_margin_o == 7'(DEPTH)) done = 1;
        end
        grant = 1'b0;
    endtask

    // Packet model: split the written word list by id runs and the length in force at each header
    task automatic build_expected();
        int k = 0;
        exp_q.delete();
        while (wq.size() > 0) begin
            logic [1:0] id = wq[0].id;
            int len = (k < lens_q.size()) ? (4 << lens_q[k]) : 4;
            int n = 0;
            logic [31:0] par = '0;
            k++;
            exp_q.push_back(mk(1'b1, 1'b0, id, {8'hA5, 6'b0, id, seq_model}));
            while (wq.size() > 0 && wq[0].id == id && n < len) begin
                wr_t w = wq.pop_front();
                bit last;
                n++;
                par ^= w.d;
                last = (n == len) || (wq.size() == 0) || (wq[0].id != id);
                exp_q.push_back(mk(1'b0, last && !PAR, id, w.d));
            end
            if (PAR) exp_q.push_back(mk(1'b0, 1'b1, id, par));
            seq_model++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fmt_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", fmt_req_o); end
        checks++; if (fmt_start_o !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", fmt_start_o); end
        checks++; if (fmt_end_o !== 1'b0) begin errors++; $display("FAIL rst_end: got %b want 0", fmt_end_o); end
        checks++; if (fmt_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", fmt_data_o); end
        checks++; if (fmt_id_o !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", fmt_id_o); end
        checks++; if (fmt_margin_o !== 7'(DEPTH)) begin errors++; $display("FAIL rst_margin: got %0d want %0d", fmt_margin_o, DEPTH); end
        checks++; if (fmt_ovf_o !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", fmt_ovf_o); end
    endtask

    task automatic test_basic();
        bit done;
        do_reset();
        pkt_len = 2'b00; grant = 1'b1;
        for (int i = 0; i < 3; i++) write_word(2'd0, 32'hC0_0000 + 32'(i));
        drain(0, done);
        checks++; if (!done) begin errors++; $display("FAIL basic_timeout: drain did not finish"); end
        checks++; if (obs_q.size() == 0 || obs_q[0].d !== 32'hA500_0000) begin
            errors++; $display("FAIL basic_hdr: got %h want a5000000", obs_q.size() ? obs_q[0].d : 32'hx);
        end
        build_expected();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        clear_obs();
    endtask

    task automatic test_len_split();
        bit done;
        do_reset();
        pkt_len = 2'b00;
        for (int i = 0; i < 10; i++) write_word(2'd1, $urandom);
        drain(0, done);
        checks++; if (!done) begin errors++; $display("FAIL len_timeout: drain did not finish"); end
        build_expected();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL len_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL len_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        clear_obs();
    endtask

    task automatic test_id_split();
        bit done;
        do_reset();
        pkt_len = 2'b01;
        write_word(2'd0, 32'h1111_0000); write_word(2'd0, 32'h1111_0001); write_word(2'd2, 32'h2222_0000);
        drain(0, done);
        checks++; if (!done) begin errors++; $display("FAIL id_timeout: drain did not finish"); end
        build_expected();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL id_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL id_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        clear_obs();
    endtask

    task automatic test_overflow();
        bit done;
        do_reset();
        pkt_len = 2'b11;
        for (int i = 0; i < 33; i++) write_word(2'd3, 32'h3300_0000 + 32'(i));
        tick();
        checks++; if (fmt_margin_o !== 7'd0) begin errors++; $display("FAIL ovf_margin: got %0d want 0", fmt_margin_o); end
        checks++; if (ovf_seen != 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ovf_seen); end
        drain(0, done);
        checks++; if (!done) begin errors++; $display("FAIL ovf_timeout: drain did not finish"); end
        build_expected();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (ovf_seen != exp_ovf) begin errors++; $display("FAIL ovf_total: got %0d want %0d", ovf_seen, exp_ovf); end
        clear_obs();
    endtask

    task automatic test_reset_mid_pay();
        bit done = 0;
        int e0;
        do_reset();
        pkt_len = 2'b01;
        for (int i = 0; i < 8; i++) write_word(2'd2, $urandom);
        grant = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin tick(); done = fmt_start_o; end
        checks++; if (!done) begin errors++; $display("FAIL rmp_timeout: no header seen"); end
        tick(); tick();
        e0 = ends_seen;
        rstn = 1'b0; mcdt_val = 1'b1; mcdt_data = 32'hDEAD_BEEF;
        tick();
        checks++; if (fmt_end_o !== 1'b0 || ends_seen != e0) begin errors++; $display("FAIL rmp_end: got end=%b ends=%0d want 0/%0d", fmt_end_o, ends_seen, e0); end
        checks++; if (fmt_data_o !== 32'h0 || fmt_start_o !== 1'b0 || fmt_req_o !== 1'b0) begin
            errors++; $display("FAIL rmp_outs: got data=%h start=%b req=%b want 0", fmt_data_o, fmt_start_o, fmt_req_o);
        end
        checks++; if (fmt_margin_o !== 7'(DEPTH)) begin errors++; $display("FAIL rmp_margin: got %0d want %0d", fmt_margin_o, DEPTH); end
        rstn = 1'b1; mcdt_val = 1'b0; grant = 1'b0;
        clear_obs(); wq.delete(); in_pkt = 0; have_end = 0; seq_model = '0; ovf_seen = 0; exp_ovf = 0;
        tick();
        checks++; if (fmt_margin_o !== 7'(DEPTH)) begin errors++; $display("FAIL rmp_discard: got margin %0d want %0d", fmt_margin_o, DEPTH); end
        write_word(2'd1, 32'h0000_0A0A); write_word(2'd1, 32'h0000_0B0B);
        drain(0, done);
        checks++; if (!done) begin errors++; $display("FAIL rmp_timeout2: drain did not finish"); end
        checks++; if (obs_q.size() == 0 || obs_q[0].d[15:0] !== 16'h0) begin errors++; $display("FAIL rmp_seq: got header %h want seq 0", obs_q.size() ? obs_q[0].d : 32'hx); end
        build_expected();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rmp_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmp_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        clear_obs();
    endtask

`ifdef MCDT_FMT_PARITY_EN
    task automatic test_parity();
        bit done;
        do_reset();
        pkt_len = 2'b00;
        write_word(2'd0, 32'h0000_000F); write_word(2'd0, 32'h0000_00F0);
        drain(0, done);
        checks++; if (!done) begin errors++; $display("FAIL par_timeout: drain did not finish"); end
        checks++; if (obs_q.size() != 4 || obs_q[3].d !== 32'h0000_00FF || obs_q[3].e !== 1'b1) begin
            errors++; $display("FAIL par_trailer: got %0d events last=%h want 4 events ending 1_000000ff", obs_q.size(), obs_q.size() ? obs_q[obs_q.size()-1] : '0);
        end
        build_expected();
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL par_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        clear_obs();
    endtask
`endif

    task automatic test_random();
        bit done;
        do_reset();
        for (int it = 0; it < 8; it++) begin
            int n = $urandom_range(1, 40);
            logic [1:0] id = 2'($urandom_range(0, 3));
            pkt_len = 2'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) id = 2'($urandom_range(0, 3));
                write_word(id, $urandom);
            end
            checks++; if (fmt_margin_o !== 7'(DEPTH - wq.size())) begin
                errors++; $display("FAIL rnd%0d_margin: got %0d want %0d", it, fmt_margin_o, DEPTH - wq.size());
            end
            drain(1, done);
            checks++; if (!done) begin errors++; $display("FAIL rnd%0d_timeout: drain did not finish", it); end
            build_expected();
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d events want %0d", it, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_ev%0d: got %h want %h", it, i, obs_q[i], exp_q[i]); end
            end
            checks++; if (ovf_seen != exp_ovf) begin errors++; $display("FAIL rnd%0d_ovf: got %0d want %0d", it, ovf_seen, exp_ovf); end
            clear_obs();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_split();
        test_id_split();
        test_overflow();
        test_reset_mid_pay();
`ifdef MCDT_FMT_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcdt_formatter.md
MCDT_FORMATTER -- requirements
Module: mcdt_formatter

Interface
REQ-001 Parameter FIFO_DEPTH, default 32, number of {id,data} entries buffered; power of two, 4..64.
REQ-002 Parameter HDR_TAG, default 8'hA5, value placed in header bits [31:24].
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rstn_i  input  1  reset, synchronous, active-low.
REQ-005 mcdt_data_i  input  32  arbitrated channel word from the mcdt stage.
REQ-006 mcdt_val_i  input  1  mcdt_data_i/mcdt_id_i valid this cycle; no backpressure exists.
REQ-007 mcdt_id_i  input  2  source channel of the word (0..2; 3 is accepted and carried).
REQ-008 pkt_len_i  input  2  max payload words: 00=4, 01=8, 10=16, 11=32; sampled on entry to HDR.
REQ-009 fmt_grant_i  input  1  downstream accepts the whole next packet; sampled only in REQ.
REQ-010 fmt_req_o  output  1  packet pending, waiting for grant.
REQ-011 fmt_start_o  output  1  header word on fmt_data_o this cycle.
REQ-012 fmt_data_o  output  32  packet word.
REQ-013 fmt_id_o  output  2  channel id of the current packet.
REQ-014 fmt_end_o  output  1  last word of the packet this cycle.
REQ-015 fmt_margin_o  output  7  free FIFO entries (FIFO_DEPTH minus count).
REQ-016 fmt_ovf_o  output  1  one-cycle pulse: an input word was dropped because the FIFO was full.

Function
REQ-017 Input write: mcdt_val_i high and FIFO not full pushes {id,data} at that edge; visible in count next cycle.
REQ-018 Write while full: word dropped, fmt_ovf_o high next cycle only; FIFO unchanged.
REQ-019 Simultaneous push and pop when full: pop frees the slot, push accepted, no overflow.
REQ-020 FSM states IDLE, REQ, HDR, PAY, TRL (TRL only with parity macro).
REQ-021 IDLE->REQ when count nonzero; fmt_req_o high from the cycle after the first word is written.
REQ-022 REQ: fmt_req_o held high until fmt_grant_i sampled high; then HDR next cycle; fmt_req_o low in HDR.
REQ-023 HDR, one cycle: fmt_start_o=1, fmt_data_o={HDR_TAG, 6'b0, head id, seq[15:0]}, fmt_id_o=head id; pkt_len latched.
REQ-024 PAY: one FIFO pop per cycle, fmt_data_o=popped data, no idle gaps; downstream cannot stall.
REQ-025 Payload word is last when: payload count reaches latched length, or count==1 at pop (concurrent write ignored), or next entry id differs from packet id.
REQ-026 Last word: fmt_end_o=1 (without parity); state to IDLE next; seq increments by 1, wraps 16'hFFFF->0.
REQ-027 Outside HDR/PAY/TRL: fmt_start_o=0, fmt_end_o=0, fmt_data_o=0; fmt_id_o holds last value.
REQ-028 Back-to-back packets: at least one IDLE and one REQ cycle between fmt_end_o and next fmt_start_o.
REQ-029 pkt_len_i changes mid-packet have no effect until next HDR.

Reset
REQ-030 rstn_i low at a rising edge: state IDLE, FIFO empty, seq=0, all outputs 0 except fmt_margin_o=FIFO_DEPTH, regardless of packet in progress.
REQ-031 Words presented while rstn_i low are discarded; packet aborted mid-PAY emits no fmt_end_o.

Configuration
REQ-032 Macro MCDT_FMT_PARITY_EN defined: after last payload word FSM enters TRL, one cycle, fmt_data_o=XOR of all payload words of the packet, fmt_end_o=1 on TRL only.
REQ-033 Macro undefined: no TRL state, no parity logic, fmt_end_o on last payload word.

Structure
REQ-034 Package mcdt_fmt_pkg holds state enum, pkt_len decode function, default HDR_TAG, header field positions.
REQ-035 FIFO is sub-module mcdt_fmt_fifo (sync, count output, push/pop same cycle); FSM in top.

Verification
REQ-036 Reset then 3 words id0 data C0_0000..C0_0002, grant immediate, pkt_len=00 -> header A5000000, 3 payload words, fmt_end_o on C0_0002.
REQ-037 10 words id1, pkt_len=00 -> packets of 4,4,2 words, headers seq 0,1,2, fmt_id_o=1.
REQ-038 Words id0,id0,id2 queued -> packet id0 (2 words), then packet id2 (1 word).
REQ-039 33 writes with grant low, FIFO_DEPTH=32 -> fmt_ovf_o pulses once, fmt_margin_o=0, 33rd word never output.
REQ-040 Reset asserted mid-PAY -> outputs 0 next cycle, fmt_margin_o=32, next header seq=0.
REQ-041 With MCDT_FMT_PARITY_EN, payload 0000_000F,0000_00F0 -> trailer 0000_00FF with fmt_end_o.
